execute_stage: RTL

Execute (EX) stage of the 5-stage MIPS pipeline. Consumes the ID/EX register outputs from instruction decode and performs ALU operations, branch compare and target generation, and jal link-value generation. It registers the results into the EX/MEM pipeline register for the memory stage. `mul` runs on a 32-cycle iterative shift-add multiplier, and the stage stalls upstream while it runs.

---
 rtl/execute_stage_if.sv | 29 ++
 rtl/execute_stage.sv | 86 ++++++++
 2 files changed

// File: rtl/execute_stage_if.sv
// execute_stage_if: ID/EX operands and controls in, EX/MEM register outputs and stall back out
interface execute_stage_if;
   logic [1:0] curr_state;
   logic MemtoReg, RegWrite, MemRead, MemWrite;
   logic branch, jump, DX_jal;
   logic [2:0] ALUctr;
   logic [31:0] A, B;
   logic [15:0] imm;
   logic [31:0] NPC, JT, DX_jaladdr, DX_swaddr;
   logic [4:0] RD;
   logic XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite;
   logic [31:0] XM_ALUout, XM_MD;
   logic [4:0] XM_RD;
   logic XM_taken;
   logic [31:0] XM_target;
   logic stall;
   modport master (
      output curr_state, MemtoReg, RegWrite, MemRead, MemWrite, branch, jump, DX_jal,
             ALUctr, A, B, imm, NPC, JT, DX_jaladdr, DX_swaddr, RD,
      input  XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_ALUout, XM_MD,
             XM_RD, XM_taken, XM_target, stall
   );
   modport slave (
      input  curr_state, MemtoReg, RegWrite, MemRead, MemWrite, branch, jump, DX_jal,
             ALUctr, A, B, imm, NPC, JT, DX_jaladdr, DX_swaddr, RD,
      output XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_ALUout, XM_MD,
             XM_RD, XM_taken, XM_target, stall
   );
endinterface

// File: rtl/execute_stage.sv
// execute_stage: MIPS EX stage with ALU, branch/jump redirect and iterative shift-add multiplier
module execute_stage #(
   parameter int MUL_CYCLES = 32
) (
   input logic clk,
   input logic rst,
   execute_stage_if.slave bus
);
   typedef enum logic {S_IDLE, S_MUL} state_t;
   state_t state, state_nx;
   logic run, is_mul, last, taken;
   logic [4:0] cnt, l_rd;
   logic [31:0] mcand, mplier, prod, prod_nx, alu, br_target, target, l_md;
   logic l_m2r, l_rw, l_mr, l_mw;

   assign run = bus.curr_state == 2'b01;
   assign is_mul = bus.ALUctr == 3'd5;
   assign last = cnt == 5'(MUL_CYCLES - 1);
   assign prod_nx = prod + (mplier[0] ? mcand : 32'd0);
   assign bus.stall = state == S_MUL;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= S_IDLE;
      else if (run) state <= state_nx;

   always_comb begin
      state_nx = state;
      state_nx = state == S_IDLE ? (is_mul ? S_MUL : S_IDLE) : (last ? S_IDLE : S_MUL);
   end

   always_comb begin
      alu = bus.ALUctr == 3'd0 ? bus.A + bus.B :
            bus.ALUctr == 3'd1 ? bus.A - bus.B :
            bus.ALUctr == 3'd2 ? bus.A & bus.B :
            bus.ALUctr == 3'd3 ? bus.A | bus.B :
            bus.ALUctr == 3'd4 ? {31'd0, $signed(bus.A) < $signed(bus.B)} :
            bus.ALUctr == 3'd6 ? bus.A - bus.B : 32'd0;
      br_target = bus.NPC + {{14{bus.imm[15]}}, bus.imm, 2'b00};
      taken = bus.DX_jal | bus.jump | (bus.branch && bus.A == bus.B);
      target = bus.DX_jal ? bus.DX_jaladdr : bus.jump ? bus.JT : taken ? br_target : 32'd0;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         {mcand, mplier, prod, cnt} <= '0;
         {l_m2r, l_rw, l_mr, l_mw, l_rd, l_md} <= '0;
         {bus.XM_MemtoReg, bus.XM_RegWrite, bus.XM_MemRead, bus.XM_MemWrite} <= '0;
         {bus.XM_ALUout, bus.XM_MD, bus.XM_RD, bus.XM_taken, bus.XM_target} <= '0;
      end else if (run) begin
         if (state == S_IDLE && is_mul) begin
            mcand <= bus.A;
            mplier <= bus.B;
            prod <= '0;
            cnt <= '0;
            {l_m2r, l_rw, l_mr, l_mw} <= {bus.MemtoReg, bus.RegWrite, bus.MemRead, bus.MemWrite};
            l_rd <= bus.RD;
            l_md <= bus.DX_swaddr;
            {bus.XM_MemtoReg, bus.XM_RegWrite, bus.XM_MemRead, bus.XM_MemWrite} <= '0;
            {bus.XM_ALUout, bus.XM_MD, bus.XM_RD, bus.XM_taken, bus.XM_target} <= '0;
         end else if (state == S_IDLE) begin
            bus.XM_MemtoReg <= bus.MemtoReg;
            bus.XM_RegWrite <= bus.RegWrite | bus.DX_jal;
            bus.XM_MemRead <= bus.MemRead;
            bus.XM_MemWrite <= bus.MemWrite;
            bus.XM_ALUout <= bus.DX_jal ? bus.NPC : alu;
            bus.XM_MD <= bus.DX_swaddr;
            bus.XM_RD <= bus.DX_jal ? 5'd31 : bus.RD;
            bus.XM_taken <= taken;
            bus.XM_target <= target;
         end else begin
            mcand <= mcand << 1;
            mplier <= mplier >> 1;
            prod <= prod_nx;
            cnt <= cnt + 5'd1;
            // the final add is folded in so the product leaves on the last count edge
            if (last) begin
               {bus.XM_MemtoReg, bus.XM_RegWrite, bus.XM_MemRead, bus.XM_MemWrite} <= {l_m2r, l_rw, l_mr, l_mw};
               bus.XM_ALUout <= prod_nx;
               bus.XM_MD <= l_md;
               bus.XM_RD <= l_rd;
               bus.XM_taken <= 1'b0;
               bus.XM_target <= '0;
            end
         end
      end
endmodule
